uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx serialiser between NUM_REQ byte-stream sources, e.g. the JPEG bitstream, a debug/status channel and a command-echo channel.
- Generates the baud tick (tx_tick) for the serialiser.
- Holds each grant for a whole burst, delimited by `last`, so packets from different sources never interleave on the TX line.
- Sits between the encoder-side producers and uart_tx in the FPGA top level.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- CLK_DIV, 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 2.
- ID_W, $clog2(NUM_REQ): width of the grant index.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ x 8  per-requester byte (packed array)
- req_last  in  NUM_REQ  byte is the final byte of the burst
- req_ready  out  NUM_REQ  one-hot, one-cycle accept strobe
- grant_id  out  ID_W  index of the current owner (valid while grant_vld)
- grant_vld  out  1  a burst is in progress
- tx_tick  out  1  baud tick to uart_tx, one-cycle pulse
- tx_req  out  1  byte request to uart_tx, one-cycle pulse
- tx_data  out  8  byte to uart_tx, registered
- tx_rdy  in  1  uart_tx idle indication

Behaviour:
- Reset (nrst=0, async): state=IDLE; rr_ptr=0; baud counter=0.
  - Outputs at reset: req_ready=0, grant_id=0, grant_vld=0, tx_tick=0, tx_req=0, tx_data=8'h00.
- Baud generator:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - tx_tick=1 for exactly one cycle when the counter equals CLK_DIV-1.
  - Free-running and independent of state.
- State IDLE:
  - If any req_valid is set, the requester chosen by round-robin from rr_ptr wins.
    - Search order: rr_ptr, rr_ptr+1, … modulo NUM_REQ.
    - Winner is latched into grant_id; grant_vld=1; next state SEND.
  - Arbitration takes 1 cycle. No byte is accepted in IDLE.
- State SEND: when req_valid[grant_id] && tx_rdy:
  - req_ready[grant_id]=1, tx_req=1 and tx_data=req_data[grant_id], all in the same cycle (registered outputs presented as one aligned pulse).
  - The last flag is latched; next state BUSY.
  - Otherwise the scheduler waits; the grant is held indefinitely (no timeout) even while req_valid[grant_id]=0.
- State BUSY:
  - Waits for tx_rdy=0, i.e. the serialiser has left idle. This guards against re-issuing on a stale tx_rdy.
  - On tx_rdy=0:
    - If the latched last=1: grant_vld=0, rr_ptr=grant_id+1 (wrapping to 0 past NUM_REQ-1), next state IDLE.
    - Otherwise: next state SEND.
- Throughput: one byte per UART frame. Back-to-back bytes of a burst issue on the first cycle tx_rdy returns high.
- Requests from non-granted requesters are ignored; their req_ready stays 0.
- Simultaneous requests in IDLE are resolved by rr_ptr only.
- A requester whose req_valid drops mid-burst keeps the grant.
- NUM_REQ that is not a power of two: rr_ptr and grant_id never take values ≥ NUM_REQ.
- Reset mid-frame aborts the burst. The requester must re-send the burst; uart_tx is reset by the same nrst.

Optional Feature:
- Macro: UART_SCHED_HDR_EN.
- Defined:
  - A new state HDR sits between IDLE and SEND.
  - On entering HDR with tx_rdy=1, the scheduler sends the header byte {4'hA, 1'b0, grant_id zero-extended to 3 bits} via tx_req.
  - No req_ready is asserted for the header byte.
  - It then waits for tx_rdy=0 and enters SEND.
  - Each burst is therefore preceded by one tagged byte that the host uses for demultiplexing.
- Undefined: no HDR state; bursts are raw bytes only.

Decomposition:
- Package uart_sched_pkg:
  - state enum {IDLE, HDR, SEND, BUSY};
  - HDR_TAG=4'hA;
  - function rr_pick(valid, ptr) returning the winning index.
- Sub-module uart_baud_gen (CLK_DIV parameter, tx_tick output), reusable by a future uart_rx.

Test Plan:
- Single requester 0 sends 3 bytes 8'h55, 8'hAA, 8'hFF (last on 8'hFF), with CLK_DIV=4 and a uart_tx model -> exactly 3 tx_req pulses with matching data and 3 req_ready[0] pulses; grant_vld falls after the byte-3 BUSY exit; rr_ptr=1.
- Requesters 0 and 1 both valid in IDLE with rr_ptr=0, 2-byte bursts each -> line order 0,0,1,1, never interleaved; next simultaneous request goes to 0 again only after 1 has been served.
- tx_tick period with CLK_DIV=4 -> pulse every 4 cycles, width 1; after reset, the first pulse arrives at cycle 4.
- Granted requester drops req_valid for 50 cycles mid-burst while requester 1 is valid -> no tx_req during the gap, grant_id unchanged, req_ready[1] stays 0.
- nrst asserted during BUSY of a 4-byte burst -> all outputs reach reset values immediately (async); after release, a new arbitration starts from rr_ptr=0.
- With UART_SCHED_HDR_EN and requester 1 granted -> first TX byte is 8'hA1 with no req_ready pulse, followed by the payload bytes.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART TX scheduler: FSM states, header tag
// and the round-robin pick used for arbitration between byte sources.
package uart_sched_pkg;

  typedef enum logic [1:0] {IDLE, HDR, SEND, BUSY} state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // First set bit of valid at or after ptr, searching modulo n (n <= 8).
  // Returns ptr when nothing is valid; callers only use it when |valid.
  function automatic int rr_pick(input logic [7:0] valid, input int ptr, input int n);
    int   idx;
    logic found;
    found   = 1'b0;
    rr_pick = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && valid[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud tick generator: one-cycle pulse every CLK_DIV clocks.
module uart_baud_gen #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic nrst,
  output logic tx_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tx_tick = (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_cnt <= '0;
    else       r_cnt <= tx_tick ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin burst scheduler sharing one uart_tx between NUM_REQ byte sources.
// Define UART_SCHED_HDR_EN to prefix every burst with a tagged header byte.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 868,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic                    grant_vld,
  output logic                    tx_tick,
  output logic                    tx_req,
  output logic [7:0]              tx_data,
  input  logic                    tx_rdy
);

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_grant_vld;
  logic               r_last;
  logic               r_tx_req;
  logic [7:0]         r_tx_data;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [7:0]         w_valid8;
  logic [ID_W-1:0]    w_pick;

  always_comb begin
    w_valid8                = '0;
    w_valid8[NUM_REQ-1:0]   = req_valid;
  end

  assign w_pick = ID_W'(rr_pick(w_valid8, int'(r_rr_ptr), NUM_REQ));

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .nrst    (nrst),
    .tx_tick (tx_tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_grant_vld <= 1'b0;
      r_last      <= 1'b0;
      r_tx_req    <= 1'b0;
      r_tx_data   <= 8'h00;
      r_req_ready <= '0;
    end else begin
      r_req_ready <= '0;
      r_tx_req    <= 1'b0;
      case (r_state)
        IDLE: if (|req_valid) begin
          r_grant_id  <= w_pick;
          r_grant_vld <= 1'b1;
`ifdef UART_SCHED_HDR_EN
          r_state     <= HDR;
`else
          r_state     <= SEND;
`endif
        end
`ifdef UART_SCHED_HDR_EN
        // Header reuses BUSY with last cleared so the burst continues into SEND.
        HDR: if (tx_rdy) begin
          r_tx_req  <= 1'b1;
          r_tx_data <= {HDR_TAG, 1'b0, 3'(r_grant_id)};
          r_last    <= 1'b0;
          r_state   <= BUSY;
        end
`endif
        SEND: if (req_valid[r_grant_id] && tx_rdy) begin
          r_req_ready[r_grant_id] <= 1'b1;
          r_tx_req                <= 1'b1;
          r_tx_data               <= req_data[r_grant_id];
          r_last                  <= req_last[r_grant_id];
          r_state                 <= BUSY;
        end
        // tx_rdy is still high the cycle after tx_req; wait for it to drop.
        BUSY: if (!tx_rdy) begin
          if (r_last) begin
            r_grant_vld <= 1'b0;
            r_rr_ptr    <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
            r_state     <= IDLE;
          end else begin
            r_state     <= SEND;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign grant_id  = r_grant_id;
  assign grant_vld = r_grant_vld;
  assign tx_req    = r_tx_req;
  assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a uart_tx model, per-source byte queues
// and an expected-byte scoreboard checked on every tx_req pulse.
module tb_uart_tx_sched;

  localparam int NR    = 2;
  localparam int CD    = 4;
  localparam int FRAME = 10 * CD;
`ifdef UART_SCHED_HDR_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic                clk  = 1'b0;
  logic                nrst = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0][7:0]  req_data  = '0;
  logic [NR-1:0]       req_last  = '0;
  logic [NR-1:0]       req_ready;
  logic [0:0]          grant_id;
  logic                grant_vld, tx_tick, tx_req, tx_rdy;
  logic [7:0]          tx_data;

  typedef struct {
    logic [7:0]    d;
    logic [NR-1:0] rdy;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [8:0]    srcq[NR][$];
  logic [NR-1:0] src_en = '1;
  logic          m_busy;
  int            m_cnt;
  int            total = 0, passed = 0, n_stray = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(NR), .CLK_DIV(CD)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .grant_vld (grant_vld),
    .tx_tick   (tx_tick),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_rdy    (tx_rdy)
  );

  // uart_tx model: busy for one frame after each accepted tx_req.
  assign tx_rdy = !m_busy;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (tx_req && !m_busy) begin
      m_busy <= 1'b1;
      m_cnt  <= FRAME;
    end else if (m_busy) begin
      if (m_cnt == 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Byte sources: pop on the accept strobe, present the queue head.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (src_en[i] && srcq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i]  = srcq[i][0][7:0];
        req_last[i]  = srcq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'h00;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Scoreboard: every tx_req must match the next expected byte and strobe.
  always @(negedge clk) begin
    if (nrst) begin
      if (tx_req) begin
        if (exp_q.size() == 0) chk("unexpected_tx", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(mon_e.d));
          chk("req_ready", 32'(req_ready), 32'(mon_e.rdy));
        end
      end else if (req_ready != '0) begin
        n_stray++;
      end
    end
  end

  task automatic add(input int id, input logic [7:0] d, input logic last);
    srcq[id].push_back({last, d});
  endtask

  task automatic expb(input int id, input logic [7:0] d);
    logic [NR-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    exp_q.push_back('{d, oh});
  endtask

  task automatic exp_hdr(input int id);
`ifdef UART_SCHED_HDR_EN
    logic [7:0] h;
    h = 8'hA0 | 8'(id);
    exp_q.push_back('{h, '0});
`else
    if (id < 0) $display("bad id %0d", id);
`endif
  endtask

  task automatic wait_tx(input int n, input string tag);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (tx_req) seen++;
    end
    chk(tag, seen, n);
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || !tx_rdy) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int gap_tx;
    #23;
    chk("rst_outs", 32'({req_ready, grant_id, grant_vld, tx_tick, tx_req, tx_data}), 0);
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("tick", 32'(tx_tick), 32'(k % 4 == 3));
    end

    // Single source, three-byte burst.
    exp_hdr(0); expb(0, 8'h55); expb(0, 8'hAA); expb(0, 8'hFF);
    add(0, 8'h55, 1'b0); add(0, 8'hAA, 1'b0); add(0, 8'hFF, 1'b1);
    drain("b_drain");
    chk("b_gvld", 32'(grant_vld), 0);
    chk("b_stray", n_stray, 0);

    // Pointer now at 1: simultaneous bursts go 1 then 0.
    exp_hdr(1); expb(1, 8'h10); expb(1, 8'h11);
    exp_hdr(0); expb(0, 8'h20); expb(0, 8'h21);
    add(0, 8'h20, 1'b0); add(0, 8'h21, 1'b1);
    add(1, 8'h10, 1'b0); add(1, 8'h11, 1'b1);
    drain("c_drain");
    chk("c_stray", n_stray, 0);

    // Async reset while BUSY in a 4-byte burst.
    exp_hdr(0);
    for (int b = 0; b < 4; b++) begin
      expb(0, 8'h30 + 8'(b));
      add(0, 8'h30 + 8'(b), 1'(b == 3));
    end
    wait_tx(HB + 2, "d_wait");
    #1 nrst = 1'b0;
    #1;
    chk("d_rst_outs", 32'({req_ready, grant_id, grant_vld, tx_tick, tx_req, tx_data}), 0);
    chk("d_rst_gvld", 32'(grant_vld), 0);
    exp_q.delete();
    srcq[0].delete();
    srcq[1].delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // After reset pointer restarts at 0: order 0,0,1,1.
    exp_hdr(0); expb(0, 8'h40); expb(0, 8'h41);
    exp_hdr(1); expb(1, 8'h50); expb(1, 8'h51);
    add(1, 8'h50, 1'b0); add(1, 8'h51, 1'b1);
    add(0, 8'h40, 1'b0); add(0, 8'h41, 1'b1);
    drain("d2_drain");

    // 1 was served last, so 0 wins the next tie.
    exp_hdr(0); expb(0, 8'h60);
    exp_hdr(1); expb(1, 8'h70);
    add(0, 8'h60, 1'b1); add(1, 8'h70, 1'b1);
    drain("e_drain");

    // Granted source goes quiet mid-burst while source 1 waits.
    exp_hdr(0); expb(0, 8'hA1); expb(0, 8'hA2);
    exp_hdr(1); expb(1, 8'hB1);
    add(0, 8'hA1, 1'b0); add(0, 8'hA2, 1'b1); add(1, 8'hB1, 1'b1);
    wait_tx(HB + 1, "f_wait");
    src_en[0] = 1'b0;
    gap_tx = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_req) gap_tx++;
      if (k == 25) begin
        chk("f_gap_gid", 32'(grant_id), 0);
        chk("f_gap_gvld", 32'(grant_vld), 1);
      end
    end
    chk("f_gap_tx", gap_tx, 0);
    chk("f_gap_stray", n_stray, 0);
    src_en[0] = 1'b1;
    drain("f_drain");
    chk("f_stray", n_stray, 0);
    chk("f_gvld", 32'(grant_vld), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
